// File: rtl/sdram_request_queue_if.sv
// -----------------------------------------------------------------------------
// sdram_request_queue_if
// Bundles the client command channel, the controller request/ack channel and
// the read response/status outputs of sdram_request_queue.
//   slave  : the queue's view (drives ready, requests, responses, status)
//   master : the environment's view (client plus controller side)
// Signals:
//   icmd_valid/icmd_write/icmd_address/icmd_wdata, ocmd_ready : client push
//   owrite_req/owrite_address/owrite_data, iwrite_ack          : write issue
//   oread_req/oread_address, iread_data/iread_ack              : read issue
//   orsp_valid/orsp_data                                       : read response
//   ooccupancy/obusy                                           : status
// -----------------------------------------------------------------------------
interface sdram_request_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 22,
  parameter int DATA_W = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              icmd_valid;
  logic              icmd_write;
  logic [ADDR_W-1:0] icmd_address;
  logic [DATA_W-1:0] icmd_wdata;
  logic              ocmd_ready;
  logic              owrite_req;
  logic [ADDR_W-1:0] owrite_address;
  logic [DATA_W-1:0] owrite_data;
  logic              iwrite_ack;
  logic              oread_req;
  logic [ADDR_W-1:0] oread_address;
  logic [DATA_W-1:0] iread_data;
  logic              iread_ack;
  logic              orsp_valid;
  logic [DATA_W-1:0] orsp_data;
  logic [CNT_W-1:0]  ooccupancy;
  logic              obusy;

  modport slave (
    input  icmd_valid, icmd_write, icmd_address, icmd_wdata,
    input  iwrite_ack, iread_data, iread_ack,
    output ocmd_ready, owrite_req, owrite_address, owrite_data,
    output oread_req, oread_address, orsp_valid, orsp_data,
    output ooccupancy, obusy
  );

  modport master (
    output icmd_valid, icmd_write, icmd_address, icmd_wdata,
    output iwrite_ack, iread_data, iread_ack,
    input  ocmd_ready, owrite_req, owrite_address, owrite_data,
    input  oread_req, oread_address, orsp_valid, orsp_data,
    input  ooccupancy, obusy
  );
endinterface

// File: rtl/sdram_request_queue.sv
// -----------------------------------------------------------------------------
// sdram_request_queue
// Command front end for sdram_controller. Client commands are pushed into an
// in-order FIFO; a small FSM pops one at a time, holds the write or read
// request to the controller until its ack, and returns read data to the
// client as a single-cycle response pulse.
// Ports:
//   iclk     : system clock, rising edge
//   ireset_n : asynchronous active-low reset, drops everything queued/in flight
//   bus      : sdram_request_queue_if.slave (client, controller, status)
// -----------------------------------------------------------------------------
module sdram_request_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 22,
  parameter int DATA_W = 16
) (
  input  logic                  iclk,
  input  logic                  ireset_n,
  sdram_request_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE_WR = 2'd1,
    ST_ISSUE_RD = 2'd2,
    ST_RESP     = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic              fifo_write_q [DEPTH];
  logic [ADDR_W-1:0] fifo_addr_q  [DEPTH];
  logic [DATA_W-1:0] fifo_data_q  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // FSM state and registered controller/client outputs
  state_t            state_q;
  logic              owrite_req_q;
  logic [ADDR_W-1:0] owrite_address_q;
  logic [DATA_W-1:0] owrite_data_q;
  logic              oread_req_q;
  logic [ADDR_W-1:0] oread_address_q;
  logic              orsp_valid_q;
  logic [DATA_W-1:0] orsp_data_q;

  logic push_s;
  logic pop_s;
  logic ready_s;
  logic empty_s;

  assign ready_s = (count_q != CNT_W'(DEPTH));
  assign empty_s = (count_q == CNT_W'(0));
  assign push_s  = bus.icmd_valid && ready_s;
  // The FSM only takes a new command while idle, so at most one is in flight.
  assign pop_s   = (state_q == ST_IDLE) && !empty_s;

  // Next-state pointers and entry count; push and pop together cancel out.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer, count and entry storage registers.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        fifo_write_q[i] <= 1'b0;
        fifo_addr_q[i]  <= ADDR_W'(0);
        fifo_data_q[i]  <= DATA_W'(0);
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_s) begin
        fifo_write_q[wr_ptr_q] <= bus.icmd_write;
        fifo_addr_q[wr_ptr_q]  <= bus.icmd_address;
        fifo_data_q[wr_ptr_q]  <= bus.icmd_wdata;
      end
    end
  end

  // Issue FSM: pop in IDLE, hold the request until its ack, pulse the response.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q          <= ST_IDLE;
      owrite_req_q     <= 1'b0;
      owrite_address_q <= ADDR_W'(0);
      owrite_data_q    <= DATA_W'(0);
      oread_req_q      <= 1'b0;
      oread_address_q  <= ADDR_W'(0);
      orsp_valid_q     <= 1'b0;
      orsp_data_q      <= DATA_W'(0);
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Acks seen here belong to no pending request and are dropped.
          if (pop_s) begin
            if (fifo_write_q[rd_ptr_q]) begin
              owrite_address_q <= fifo_addr_q[rd_ptr_q];
              owrite_data_q    <= fifo_data_q[rd_ptr_q];
              owrite_req_q     <= 1'b1;
              state_q          <= ST_ISSUE_WR;
            end else begin
              oread_address_q  <= fifo_addr_q[rd_ptr_q];
              oread_req_q      <= 1'b1;
              state_q          <= ST_ISSUE_RD;
            end
          end
        end
        ST_ISSUE_WR: begin
          // Dropping the request on the ack edge keeps it from being
          // seen again by the controller's next idle cycle.
          if (bus.iwrite_ack) begin
            owrite_req_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        ST_ISSUE_RD: begin
          if (bus.iread_ack) begin
            orsp_data_q  <= bus.iread_data;
            orsp_valid_q <= 1'b1;
            oread_req_q  <= 1'b0;
            state_q      <= ST_RESP;
          end
        end
        ST_RESP: begin
          orsp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          owrite_req_q <= 1'b0;
          oread_req_q  <= 1'b0;
          orsp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ocmd_ready     = ready_s;
  assign bus.owrite_req     = owrite_req_q;
  assign bus.owrite_address = owrite_address_q;
  assign bus.owrite_data    = owrite_data_q;
  assign bus.oread_req      = oread_req_q;
  assign bus.oread_address  = oread_address_q;
  assign bus.orsp_valid     = orsp_valid_q;
  assign bus.orsp_data      = orsp_data_q;
  assign bus.ooccupancy     = count_q;
  assign bus.obusy          = !empty_s || (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdram_request_queue.sv
// -----------------------------------------------------------------------------
// tb_sdram_request_queue
// Directed bench for sdram_request_queue: the bench plays both the client and
// the controller, with hand-computed expectations for every comparison.
// -----------------------------------------------------------------------------
module tb_sdram_request_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;

  logic iclk;
  logic ireset_n;
  int   n_checks;
  int   n_fail;

  sdram_request_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_request_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .iclk     (iclk),
    .ireset_n (ireset_n),
    .bus      (bus)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // Compare one observed value with its expected value and count it.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic push(input logic wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    bus.icmd_valid   = 1'b1;
    bus.icmd_write   = wr;
    bus.icmd_address = addr;
    bus.icmd_wdata   = data;
    tick();
    bus.icmd_valid   = 1'b0;
  endtask

  // Act as the controller for one command: wait for the request, check it,
  // hold it for 'delay' extra cycles, ack it and check the response.
  task automatic serve(input string tag, input logic is_wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] rdata,
                       input int delay);
    int waited;
    waited = 0;
    while (!(bus.owrite_req || bus.oread_req) && waited < 30) begin
      tick();
      waited++;
    end
    check_eq({tag, " req_seen"}, 32'(bus.owrite_req | bus.oread_req), 32'd1);
    check_eq({tag, " req_kind"}, 32'(bus.owrite_req), 32'(is_wr));
    if (is_wr) begin
      check_eq({tag, " wr_addr"}, 32'(bus.owrite_address), 32'(addr));
      check_eq({tag, " wr_data"}, 32'(bus.owrite_data), 32'(wdata));
    end else begin
      check_eq({tag, " rd_addr"}, 32'(bus.oread_address), 32'(addr));
    end
    for (int i = 0; i < delay; i++) begin
      tick();
      check_eq({tag, " req_held"}, {30'd0, bus.owrite_req, bus.oread_req},
               is_wr ? 32'd2 : 32'd1);
    end
    if (is_wr) begin
      bus.iwrite_ack = 1'b1;
    end else begin
      bus.iread_data = rdata;
      bus.iread_ack  = 1'b1;
    end
    tick();
    bus.iwrite_ack = 1'b0;
    bus.iread_ack  = 1'b0;
    bus.iread_data = 16'h0000;
    check_eq({tag, " req_drop"}, {30'd0, bus.owrite_req, bus.oread_req}, 32'd0);
    if (is_wr) begin
      check_eq({tag, " no_rsp"}, 32'(bus.orsp_valid), 32'd0);
    end else begin
      check_eq({tag, " rsp_valid"}, 32'(bus.orsp_valid), 32'd1);
      check_eq({tag, " rsp_data"}, 32'(bus.orsp_data), 32'(rdata));
      tick();
      check_eq({tag, " rsp_pulse_end"}, 32'(bus.orsp_valid), 32'd0);
      check_eq({tag, " rsp_data_hold"}, 32'(bus.orsp_data), 32'(rdata));
    end
  endtask

  // Overall time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    ireset_n         = 1'b0;
    bus.icmd_valid   = 1'b0;
    bus.icmd_write   = 1'b0;
    bus.icmd_address = 22'h0;
    bus.icmd_wdata   = 16'h0;
    bus.iwrite_ack   = 1'b0;
    bus.iread_ack    = 1'b0;
    bus.iread_data   = 16'h0;

    // Reset state
    repeat (2) tick();
    check_eq("rst owrite_req", 32'(bus.owrite_req), 32'd0);
    check_eq("rst oread_req", 32'(bus.oread_req), 32'd0);
    check_eq("rst orsp_valid", 32'(bus.orsp_valid), 32'd0);
    check_eq("rst occupancy", 32'(bus.ooccupancy), 32'd0);
    check_eq("rst obusy", 32'(bus.obusy), 32'd0);
    ireset_n = 1'b1;
    tick();
    check_eq("rst ready", 32'(bus.ocmd_ready), 32'd1);

    // Single write
    push(1'b1, 22'h12345, 16'hBEEF);
    check_eq("w1 occ_after_push", 32'(bus.ooccupancy), 32'd1);
    tick();
    check_eq("w1 obusy", 32'(bus.obusy), 32'd1);
    serve("w1", 1'b1, 22'h12345, 16'hBEEF, 16'h0000, 3);
    check_eq("w1 idle_busy", 32'(bus.obusy), 32'd0);

    // Single read, ack during the 6th request cycle
    push(1'b0, 22'h00ABC, 16'h0000);
    serve("r1", 1'b0, 22'h00ABC, 16'h0000, 16'h5A5A, 5);

    // Four back-to-back mixed commands served in order
    push(1'b1, 22'h00A01, 16'h1A1A);
    push(1'b0, 22'h00B02, 16'h0000);
    push(1'b1, 22'h00C03, 16'h3C3C);
    push(1'b0, 22'h00D04, 16'h0000);
    serve("seqA", 1'b1, 22'h00A01, 16'h1A1A, 16'h0000, 2);
    serve("seqB", 1'b0, 22'h00B02, 16'h0000, 16'hB0B0, 3);
    serve("seqC", 1'b1, 22'h00C03, 16'h3C3C, 16'h0000, 1);
    serve("seqD", 1'b0, 22'h00D04, 16'h0000, 16'hD0D0, 2);
    check_eq("seq idle", 32'(bus.obusy), 32'd0);

    // Fill: one in flight plus four queued
    bus.icmd_valid = 1'b1;
    bus.icmd_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.icmd_address = 22'h100 + 22'(i);
      bus.icmd_wdata   = 16'h7000 + 16'(i);
      tick();
    end
    bus.icmd_valid = 1'b0;
    check_eq("full occ", 32'(bus.ooccupancy), 32'd4);
    check_eq("full ready", 32'(bus.ocmd_ready), 32'd0);
    check_eq("full head_addr", 32'(bus.owrite_address), 32'h100);
    bus.iwrite_ack = 1'b1;
    tick();
    bus.iwrite_ack = 1'b0;
    // Ack edge returns the FSM to IDLE; the pop that frees a slot is one edge later.
    check_eq("full ready_idle", 32'(bus.ocmd_ready), 32'd0);
    tick();
    check_eq("full ready_back", 32'(bus.ocmd_ready), 32'd1);
    check_eq("full occ_after", 32'(bus.ooccupancy), 32'd3);
    for (int i = 1; i < 5; i++) begin
      serve("drain", 1'b1, 22'h100 + 22'(i), 16'h7000 + 16'(i), 16'h0000, 1);
    end

    // Ack held for two cycles consumes only one command
    push(1'b1, 22'h200, 16'h1111);
    push(1'b1, 22'h201, 16'h2222);
    check_eq("dack first_addr", 32'(bus.owrite_address), 32'h200);
    bus.iwrite_ack = 1'b1;
    tick();
    check_eq("dack drop", 32'(bus.owrite_req), 32'd0);
    tick();
    bus.iwrite_ack = 1'b0;
    check_eq("dack next_req", 32'(bus.owrite_req), 32'd1);
    check_eq("dack next_addr", 32'(bus.owrite_address), 32'h201);
    check_eq("dack next_data", 32'(bus.owrite_data), 32'h2222);
    check_eq("dack occ", 32'(bus.ooccupancy), 32'd0);
    repeat (2) begin
      tick();
      check_eq("dack still_req", 32'(bus.owrite_req), 32'd1);
    end
    bus.iwrite_ack = 1'b1;
    tick();
    bus.iwrite_ack = 1'b0;
    tick();
    check_eq("dack done_req", 32'(bus.owrite_req), 32'd0);
    check_eq("dack done_busy", 32'(bus.obusy), 32'd0);

    // Asynchronous reset in the middle of a read
    push(1'b0, 22'h300, 16'h0000);
    push(1'b0, 22'h301, 16'h0000);
    check_eq("arst rd_req", 32'(bus.oread_req), 32'd1);
    check_eq("arst occ_pre", 32'(bus.ooccupancy), 32'd1);
    #3;
    ireset_n = 1'b0;
    #1;
    check_eq("arst rd_req_low", 32'(bus.oread_req), 32'd0);
    check_eq("arst occ_zero", 32'(bus.ooccupancy), 32'd0);
    check_eq("arst rsp_low", 32'(bus.orsp_valid), 32'd0);
    tick();
    ireset_n = 1'b1;
    #1;
    check_eq("arst ready", 32'(bus.ocmd_ready), 32'd1);
    bus.iread_data = 16'hDEAD;
    bus.iread_ack  = 1'b1;
    tick();
    bus.iread_ack  = 1'b0;
    check_eq("arst stale_rsp", 32'(bus.orsp_valid), 32'd0);
    tick();
    check_eq("arst stale_rsp2", 32'(bus.orsp_valid), 32'd0);
    check_eq("arst rsp_data", 32'(bus.orsp_data), 32'd0);
    check_eq("arst idle", 32'(bus.obusy), 32'd0);
    check_eq("arst no_req", {30'd0, bus.owrite_req, bus.oread_req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_request_queue.md
Name: sdram_request_queue

Overview:
Upstream command stage for sdram_controller. It accepts read and write commands from a client over a valid/ready interface and buffers them in an in-order FIFO. It issues them one at a time to the controller's iwrite_req/iread_req ports, holding each request until the matching ack. Read data is returned to the client as a one-cycle response pulse, in command order.

Parameters:
DEPTH, 4, number of command FIFO entries (power of 2, min 2)
ADDR_W, 22, command address width (matches controller address ports)
DATA_W, 16, data width

Ports:
iclk  in  1  system clock, all logic on rising edge
ireset_n  in  1  asynchronous active-low reset
icmd_valid  in  1  client command valid
icmd_write  in  1  1=write, 0=read
icmd_address  in  ADDR_W  command address
icmd_wdata  in  DATA_W  write data (ignored for reads)
ocmd_ready  out  1  FIFO can accept a command this cycle
owrite_req  out  1  write request to controller
owrite_address  out  ADDR_W  write address to controller
owrite_data  out  DATA_W  write data to controller
iwrite_ack  in  1  controller write-done pulse
oread_req  out  1  read request to controller
oread_address  out  ADDR_W  read address to controller
iread_data  in  DATA_W  controller read data, valid with iread_ack
iread_ack  in  1  controller read-done pulse
orsp_valid  out  1  read response pulse to client
orsp_data  out  DATA_W  read response data
ooccupancy  out  log2(DEPTH)+1  FIFO entry count
obusy  out  1  FIFO non-empty or a request is in flight

Behaviour:
- Reset (ireset_n low, asynchronous): FIFO empty. ocmd_ready=1 once reset is released. All other outputs = 0. FSM = IDLE. Reset mid-operation drops queued and in-flight commands without any response.
- FIFO push: when icmd_valid && ocmd_ready. Entry = {write, address, wdata}.
- ocmd_ready = (occupancy != DEPTH). It is combinational from registered count.
- ooccupancy tracks the count. A push and a pop in the same cycle leave the count unchanged. A push while full is impossible because ready=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- FSM states: IDLE, ISSUE_WR, ISSUE_RD, RESP.
- IDLE:
  - If the FIFO is non-empty, pop the head into the output registers.
  - Go to ISSUE_WR if the head is a write, else ISSUE_RD.
  - Registered owrite_req or oread_req asserts in the cycle after the pop.
- ISSUE_WR:
  - owrite_req=1. owrite_address and owrite_data are held stable.
  - On iwrite_ack=1, clear owrite_req at that edge and go to IDLE.
  - The request never remains high into the controller's next IDLE cycle, so no duplicate issue occurs.
- ISSUE_RD:
  - oread_req=1. oread_address is held stable.
  - On iread_ack=1, capture iread_data into orsp_data, clear oread_req, and go to RESP.
- RESP: orsp_valid=1 for exactly one cycle, then go to IDLE. orsp_data holds its value until the next read response.
- Exactly one of owrite_req/oread_req is ever high. At most one command is in flight.
- Acks arriving while no matching request is pending are ignored, e.g. iwrite_ack while in ISSUE_RD, or any ack in IDLE.
- Minimum command-to-command spacing on the controller side is 1 idle cycle between req deassert and the next req assert (the IDLE pop cycle).
- obusy = (occupancy != 0) || (state != IDLE).
- Push while the FSM is issuing is allowed. The FIFO fills independently of the controller handshake.

Test Plan:
- Reset then single write (addr 0x12345, data 0xBEEF) -> owrite_req high with those values until iwrite_ack. No orsp_valid is produced. obusy=0 afterwards.
- Single read (addr 0x00ABC) with controller returning 0x5A5A plus ack after 6 cycles -> oread_req held 6 cycles. orsp_valid pulses 1 cycle later with orsp_data=0x5A5A.
- Push write A, read B, write C, read D back-to-back with acks delayed -> controller sees requests in order A, B, C, D. Responses for B and D are returned in order, with no overlapping reqs.
- Push 5 commands with acks withheld -> ooccupancy reaches 4 and ocmd_ready=0 (head in flight, 4 queued). After one ack, ready returns to 1 on the next cycle.
- Ack held high for 2 cycles by the testbench during a write -> only one command is consumed. The second ack cycle is ignored in IDLE, and the next queued command issues normally.
- Assert ireset_n=0 asynchronously mid-read -> oread_req, orsp_valid and ooccupancy go to 0 immediately. ocmd_ready=1 after release, and no stale response appears.
